// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_2r1w
//  Purpose  : Flop-based register file, one write port and two registered
//             read ports with write-first bypass and optional zero entry.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_2r1w #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd,
    input  logic              re0,
    input  logic [ADDR_W-1:0] ra0,
    output logic [WIDTH-1:0]  rd0,
    output logic              rv0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] ra1,
    output logic [WIDTH-1:0]  rd1,
    output logic              rv1
);

    localparam int              c_idx_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] c_depth  = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_wr_ok;
    logic [c_idx_w-1:0] w_wa_idx;

    logic               w_re  [2];
    logic [ADDR_W-1:0]  w_ra  [2];
    logic [WIDTH-1:0]   w_val [2];
    logic [WIDTH-1:0]   r_rd  [2];
    logic               r_rv  [2];

    assign w_wa_idx = wa[c_idx_w-1:0];
    assign w_wr_ok  = we && ({1'b0, wa} < c_depth) && !((ZERO_REG != 0) && (wa == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[w_wa_idx] <= wd;
        end
    end

    assign w_re[0] = re0;
    assign w_re[1] = re1;
    assign w_ra[0] = ra0;
    assign w_ra[1] = ra1;

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic               w_ra_ok;
        logic [c_idx_w-1:0] w_ra_idx;

        assign w_ra_idx = w_ra[p][c_idx_w-1:0];
        assign w_ra_ok  = ({1'b0, w_ra[p]} < c_depth) && !((ZERO_REG != 0) && (w_ra[p] == '0));

        // Write-first: a same-cycle write to the addressed entry wins over storage.
        always_comb begin
            w_val[p] = '0;
            if (w_ra_ok) begin
                if (w_wr_ok && (wa == w_ra[p])) begin
                    w_val[p] = wd;
                end else begin
                    w_val[p] = r_mem[w_ra_idx];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rd[p] <= '0;
                r_rv[p] <= 1'b0;
            end else begin
                r_rv[p] <= w_re[p];
                if (w_re[p]) begin
                    r_rd[p] <= w_val[p];
                end
            end
        end
    end

    assign rd0 = r_rd[0];
    assign rv0 = r_rv[0];
    assign rd1 = r_rd[1];
    assign rv1 = r_rv[1];

endmodule
`default_nettype wire
